outbox: RTL
===========

OUTBOX -- requirements
Module: outbox

Interface
REQ-001 Parameter DEPTH, default 16, number of 8-bit entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  system clock; all state SHALL change only on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 iData  input  8  byte to enqueue; driven by the CPU register R.
REQ-006 wO  input  1  enqueue strobe from the control unit; one byte per cycle while high.
REQ-007 iClr  input  1  synchronous flush request from the control unit.
REQ-008 oFull  output  1  queue holds DEPTH entries; the control unit stalls the OUTBOX instruction while high.
REQ-009 oEmpty  output  1  queue holds 0 entries.
REQ-010 oCount  output  AW+1  number of stored entries, 0..DEPTH.
REQ-011 oOvf  output  1  sticky flag: an enqueue was dropped.
REQ-012 oData  output  8  head entry (first-word fall-through); valid only while oValid=1.
REQ-013 oValid  output  1  consumer side: head entry available; equals !oEmpty.
REQ-014 iReady  input  1  consumer side: head entry taken this cycle when oValid=1.

Function
REQ-015 Storage SHALL be a DEPTH x 8 array with AW-bit write pointer wp, AW-bit read pointer rp and an (AW+1)-bit count.
REQ-016 Enqueue SHALL occur on a posedge when wO=1 and oFull=0 (registered value at that edge); mem[wp]<=iData, wp<=wp+1.
REQ-017 Dequeue SHALL occur on a posedge when iReady=1 and oValid=1; rp<=rp+1.
REQ-018 Pointers SHALL wrap modulo DEPTH with no extra logic (DEPTH-1 -> 0).
REQ-019 Count SHALL be +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-020 Simultaneous enqueue and dequeue SHALL be legal at any non-full count, including 1.
REQ-021 When full, wO=1 SHALL be dropped even if a dequeue occurs the same cycle; contents and wp unchanged, oOvf<=1.
REQ-022 When empty, a dequeue attempt (iReady=1, oValid=0) SHALL be ignored; no flag is set.
REQ-023 Write-to-read latency SHALL be one cycle: a byte enqueued into an empty queue at edge N SHALL appear on oData with oValid=1 after edge N; there is no same-cycle bypass.
REQ-024 oData SHALL equal mem[rp] combinationally; its value while oValid=0 is don't-care but SHALL NOT be X in simulation after reset.
REQ-025 oFull, oEmpty and oValid SHALL be derived from the registered count only (count==DEPTH, count==0).
REQ-026 iClr=1 SHALL set wp, rp and count to 0 at the next edge and SHALL take priority over a simultaneous enqueue or dequeue; oOvf SHALL also clear.
REQ-027 oOvf SHALL remain 1 once set until rst or iClr.
REQ-028 FIFO order SHALL be preserved: bytes leave oData in exactly the order they were enqueued.
REQ-029 Outside synthesis, each accepted enqueue SHALL print a debug line with time and the byte value in hex.

Reset
REQ-030 With rst=1 at a posedge: wp=0, rp=0, count=0, oOvf=0; hence oEmpty=1, oFull=0, oValid=0, oCount=0.
REQ-031 rst SHALL override iClr, wO and iReady in the same cycle.
REQ-032 Array contents SHALL NOT be reset (they are not observable while empty).
REQ-033 Reset asserted mid-stream SHALL discard all queued bytes; the first enqueue after reset lands at address 0.

Verification
REQ-034 Reset, then wO=1 with iData=0x2A for one cycle, iReady=0 -> next cycle oValid=1, oData=0x2A, oCount=1; iReady=1 one cycle -> oEmpty=1, oCount=0.
REQ-035 Enqueue 0x01..0x10 (16 bytes) with iReady=0 -> oFull=1, oCount=16; a 17th wO with 0x11 -> oOvf=1, oCount=16; drain -> 0x01..0x10 in order, 0x11 never appears.
REQ-036 Wrap: enqueue/dequeue 40 bytes with 0x00..0x27, keeping count at 3 -> output order exact, no oOvf, pointers wrapped twice.
REQ-037 Full queue with wO=1 (0x55) and iReady=1 same cycle -> dequeue happens, 0x55 dropped, oOvf=1, oCount=15.
REQ-038 Five bytes queued, oOvf=1, then iClr=1 with wO=1 (0x77) -> next cycle oEmpty=1, oCount=0, oOvf=0, 0x77 not stored.
REQ-039 Eight bytes queued, rst=1 one cycle with wO=1 and iReady=1 -> oEmpty=1, oOvf=0; next enqueue 0x99 -> oData=0x99 after one cycle.

Source files
------------

// File: rtl/outbox.sv
`default_nettype none
// ============================================================================
// Module      : outbox
// Description : Byte queue between the CPU OUTBOX instruction and a consumer,
//               first-word fall-through head, sticky overflow, sync flush.
// Revision    : 1.0 - initial release
// ============================================================================
module outbox #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    iData,
    input  logic          wO,
    input  logic          iClr,
    output logic          oFull,
    output logic          oEmpty,
    output logic [AW:0]   oCount,
    output logic          oOvf,
    output logic [7:0]    oData,
    output logic          oValid,
    input  logic          iReady
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic          w_drop;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    // Reset and flush suppress all queue traffic in their cycle.
    assign w_enq  = wO && !w_full && !iClr && !rst;
    assign w_deq  = iReady && !w_empty && !iClr && !rst;
    assign w_drop = wO && w_full && !iClr && !rst;

    // Storage is left unreset; contents are unreachable while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wp] <= iData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || iClr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_deq) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign oFull  = w_full;
    assign oEmpty = w_empty;
    assign oValid = !w_empty;
    assign oCount = r_count;
    assign oOvf   = r_ovf;
    // Masked while empty so the never-written array cannot leak X after reset.
    assign oData  = w_empty ? 8'h00 : r_mem[r_rp];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (w_enq) begin
            $display("[outbox] t=%0t enq 0x%02h", $time, iData);
        end
    end
`endif

endmodule
`default_nettype wire
